// File: rtl/alarm_pkg.sv
// Shared types and constants for the intrusion responder.
// State codes and fixed widths used by the FSM and the bench.
package alarm_pkg;

    localparam int STATE_W     = 3;
    localparam int ALARM_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_ALARM       = 3'd4
    } state_e;

endpackage

// File: rtl/alarm_input_sync.sv
// Two-flop synchronizer for asynchronous sensor/tamper inputs.
// Ports: clk, rst_n (async active-low), d (raw), q (synchronized).
module alarm_input_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/alarm_responder.sv
// Intrusion response FSM: exit delay, armed watch, entry delay, siren.
// Ports: clk, rst_n, systemArmed, disarmedState, sensor_zone, zone_enable,
//   tamper in; state, siren, armed_led, countdown, zone_latched,
//   alarm_count out.
module alarm_responder
    import alarm_pkg::*;
#(
    parameter int NUM_ZONES          = 4,
    parameter int CNT_W              = 16,
    parameter int EXIT_DELAY_CYCLES  = 1000,
    parameter int ENTRY_DELAY_CYCLES = 500,
    parameter int SIREN_CYCLES       = 4000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   systemArmed,
    input  logic                   disarmedState,
    input  logic [NUM_ZONES-1:0]   sensor_zone,
    input  logic [NUM_ZONES-1:0]   zone_enable,
    input  logic                   tamper,
    output logic [STATE_W-1:0]     state,
    output logic                   siren,
    output logic                   armed_led,
    output logic [CNT_W-1:0]       countdown,
    output logic [NUM_ZONES-1:0]   zone_latched,
    output logic [ALARM_CNT_W-1:0] alarm_count
);

    // A state loaded with N-1 is left after exactly N cycles.
    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);

    logic [STATE_W-1:0]     r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_ZONES-1:0]   r_zone_latched;
    logic [ALARM_CNT_W-1:0] r_alarm_cnt;

    logic [NUM_ZONES:0]     w_sync_in;
    logic [NUM_ZONES:0]     w_sync_out;
    logic                   w_tamper;
    logic [NUM_ZONES-1:0]   w_trip_vec;
    logic                   w_trip;
    logic                   w_arm_req;
    logic                   w_disarm_req;
    logic                   w_cnt_zero;
    logic [STATE_W-1:0]     w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [NUM_ZONES-1:0]   w_zl_nxt;
    logic                   w_enter_alarm;

    assign w_sync_in = {tamper, sensor_zone};

    alarm_input_sync #(
        .W (NUM_ZONES + 1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (w_sync_in),
        .q     (w_sync_out)
    );

    assign w_tamper     = w_sync_out[NUM_ZONES];
    assign w_trip_vec   = w_sync_out[NUM_ZONES-1:0] & zone_enable;
    assign w_trip       = |w_trip_vec;
    assign w_arm_req    = systemArmed & ~disarmedState;
    assign w_disarm_req = disarmedState;
    assign w_cnt_zero   = (r_cnt == '0);

    // Counter defaults to 0 outside the timed states so countdown stays clean.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_zl_nxt      = r_zone_latched;
        w_enter_alarm = 1'b0;
        case (r_state)
            ST_DISARMED: begin
                if (w_arm_req) begin
                    w_state_nxt = ST_EXIT_DELAY;
                    w_cnt_nxt   = EXIT_LOAD;
                    w_zl_nxt    = '0;
                end
            end
            ST_EXIT_DELAY: begin
                if (w_disarm_req)    w_state_nxt = ST_DISARMED;
                else if (w_tamper)   w_state_nxt = ST_ALARM;
                else if (w_cnt_zero) w_state_nxt = ST_ARMED;
                else                 w_cnt_nxt   = r_cnt - 1'b1;
            end
            ST_ARMED: begin
                if (w_disarm_req) begin
                    w_state_nxt = ST_DISARMED;
                end else if (w_tamper) begin
                    w_state_nxt = ST_ALARM;
                end else if (w_trip) begin
                    w_state_nxt = ST_ENTRY_DELAY;
                    w_cnt_nxt   = ENTRY_LOAD;
                    w_zl_nxt    = w_trip_vec;
                end
            end
            ST_ENTRY_DELAY: begin
                if (w_disarm_req) begin
                    w_state_nxt = ST_DISARMED;
                end else if (w_tamper) begin
                    w_state_nxt = ST_ALARM;
                end else begin
                    w_zl_nxt = r_zone_latched | w_trip_vec;
                    if (w_cnt_zero) w_state_nxt = ST_ALARM;
                    else            w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_ALARM: begin
                if (w_disarm_req) begin
                    w_state_nxt = ST_DISARMED;
                end else begin
                    w_zl_nxt = r_zone_latched | w_trip_vec;
                    if (w_cnt_zero) w_state_nxt = ST_ARMED;
                    else            w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_DISARMED;
        endcase
        // Every path into ALARM shares the siren load and the entry count.
        if (w_state_nxt == ST_ALARM && r_state != ST_ALARM) begin
            w_enter_alarm = 1'b1;
            w_cnt_nxt     = SIREN_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_DISARMED;
            r_cnt          <= '0;
            r_zone_latched <= '0;
            r_alarm_cnt    <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_zone_latched <= w_zl_nxt;
            if (w_enter_alarm && r_alarm_cnt != '1)
                r_alarm_cnt <= r_alarm_cnt + 1'b1;
        end
    end

    // Counter decrements every cycle in EXIT_DELAY, so its LSB is the blink.
    always_comb begin
        siren     = 1'b0;
        armed_led = 1'b0;
        countdown = '0;
        case (r_state)
            ST_EXIT_DELAY: begin
                armed_led = r_cnt[0];
                countdown = r_cnt;
            end
            ST_ARMED: armed_led = 1'b1;
            ST_ENTRY_DELAY: begin
                armed_led = 1'b1;
                countdown = r_cnt;
            end
            ST_ALARM: begin
                siren     = 1'b1;
                armed_led = 1'b1;
                countdown = r_cnt;
            end
            default: ;
        endcase
    end

    assign state        = r_state;
    assign zone_latched = r_zone_latched;
    assign alarm_count  = r_alarm_cnt;

endmodule
